// File: rtl/pixel_pair_serializer.sv
// pixel_pair_serializer: captures two-pixels-per-clock RGB pairs into a FIFO
// and replays them as a one-pixel-per-clock valid/ready stream with
// start-of-frame, end-of-line and last-pixel markers.
//
// Output handshake: a pixel transfers on every rising clock edge where
// m_valid and m_ready are both high. m_valid never depends on m_ready, and
// m_data plus the markers stay stable while m_valid=1 and m_ready=0.
// Only a transfer or a vsync flush changes them.
module pixel_pair_serializer #(
  parameter int IMAGE_WIDTH  = 384,
  parameter int IMAGE_HEIGHT = 256,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          vsync,
  input  logic                          hsync,
  input  logic [7:0]                    red_even,
  input  logic [7:0]                    green_even,
  input  logic [7:0]                    blue_even,
  input  logic [7:0]                    red_odd,
  input  logic [7:0]                    green_odd,
  input  logic [7:0]                    blue_odd,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [23:0]                   m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_last,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          frame_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          phase
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  // Which half of the head pair is currently presented.
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_t;

  phase_t        phase_q;
  phase_t        phase_d;
  logic [47:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          vsync_q;

  logic          empty;
  logic          full;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          vsync_rise;
  logic          col_last;
  logic          row_last;
  logic [47:0]   head;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign m_valid    = !empty;
  assign handshake  = m_valid && m_ready;
  assign pop        = handshake && (phase_q == ODD);
  // A pop in the same cycle frees the slot the incoming pair lands in.
  assign push       = hsync && (!full || pop);
  assign vsync_rise = vsync && !vsync_q;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);

  assign m_data     = !m_valid ? 24'd0 : ((phase_q == EVEN) ? head[47:24] : head[23:0]);
  assign m_sof      = m_valid && (col == '0) && (row == '0);
  assign m_eol      = m_valid && col_last;
  assign m_last     = m_eol && row_last;
  assign fifo_level = wr_ptr - rd_ptr;
  assign phase      = phase_q;

  // Pair storage; a flush cycle writes nothing.
  always_ff @(posedge clock) begin
    if (push && !vsync_rise) begin
      mem[wr_ptr[AW-1:0]] <= {red_even, green_even, blue_even, red_odd, green_odd, blue_odd};
    end
  end

  // Phase register (state of the read-side FSM).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= EVEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase next-state: flush returns to EVEN, each transfer toggles.
  always_comb begin
    phase_d = phase_q;
    if (vsync_rise) begin
      phase_d = EVEN;
    end else if (handshake) begin
      phase_d = (phase_q == EVEN) ? ODD : EVEN;
    end
  end

  // Pointers, raster counters, pulse and sticky flags; flush overrides all.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      col         <= '0;
      row         <= '0;
      vsync_q     <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_done <= 1'b0;
      if (vsync_rise) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        col    <= '0;
        row    <= '0;
        if (!empty || (col != '0) || (row != '0)) begin
          frame_error <= 1'b1;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (hsync && full && !pop) begin
          overflow <= 1'b1;
        end
        if (handshake) begin
          frame_done <= m_last;
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_pair_serializer.sv
// Directed bench for pixel_pair_serializer with a 4x2 frame and a 4-entry FIFO.
module tb_pixel_pair_serializer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        clock;
  logic        reset_n;
  logic        vsync;
  logic        hsync;
  logic [7:0]  red_even, green_even, blue_even;
  logic [7:0]  red_odd, green_odd, blue_odd;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof, m_eol, m_last;
  logic        frame_done, overflow, frame_error;
  logic [2:0]  fifo_level;
  logic        phase;

  int checks = 0;
  int errors = 0;
  int pos = 0;  // expected raster position of the next output pixel (0..W*H-1)

  pixel_pair_serializer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FIFO_DEPTH(D)
  ) dut (
    .clock(clock), .reset_n(reset_n), .vsync(vsync), .hsync(hsync),
    .red_even(red_even), .green_even(green_even), .blue_even(blue_even),
    .red_odd(red_odd), .green_odd(green_odd), .blue_odd(blue_odd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_last(m_last),
    .frame_done(frame_done), .overflow(overflow), .frame_error(frame_error),
    .fifo_level(fifo_level), .phase(phase)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel j of a sequence: R = r0+j, G = r0+10+j, B = r0+20+j.
  function automatic logic [23:0] pix(input int r0, input int j);
    logic [7:0] r, g, b;
    r = 8'(r0 + j);
    g = 8'(r0 + 10 + j);
    b = 8'(r0 + 20 + j);
    return {r, g, b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pair(input logic [23:0] e, input logic [23:0] o);
    {red_even, green_even, blue_even} = e;
    {red_odd, green_odd, blue_odd}    = o;
  endtask

  // Push n consecutive pairs; pair p carries pixels 2p and 2p+1.
  task automatic push_pairs(input int r0, input int first_pair, input int n);
    for (int k = 0; k < n; k++) begin
      set_pair(pix(r0, 2 * (first_pair + k)), pix(r0, 2 * (first_pair + k) + 1));
      hsync = 1'b1;
      tick();
    end
    hsync = 1'b0;
  endtask

  // Accept n pixels with m_ready=1, checking data, markers and frame_done.
  task automatic drain(input int r0, input int first_j, input int n);
    logic fd_exp;
    m_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk("drain_valid", m_valid, 1'b1);
      chk("drain_data", m_data, pix(r0, first_j + k));
      chk("drain_sof", m_sof, pos == 0);
      chk("drain_eol", m_eol, (pos % W) == W - 1);
      chk("drain_last", m_last, pos == W * H - 1);
      fd_exp = (pos == W * H - 1);
      tick();
      pos = (pos + 1) % (W * H);
      chk("drain_frame_done", frame_done, fd_exp);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; hsync = 1'b0; m_ready = 1'b0;
    set_pair(24'd0, 24'd0);
    #1;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_data", m_data, 24'd0);
    chk("rst_markers", {m_sof, m_eol, m_last}, 3'b000);
    chk("rst_flags", {frame_done, overflow, frame_error}, 3'b000);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // vsync on a clean, empty frame is not an error
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    chk("clean_vsync_err", frame_error, 1'b0);
    chk("clean_vsync_valid", m_valid, 1'b0);

    // Basic frame under backpressure: 4 pairs fill the FIFO, then drain 8 pixels
    set_pair(pix(10, 0), pix(10, 1));
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    chk("latency_valid", m_valid, 1'b1);
    chk("latency_data", m_data, 24'h0A141E);
    chk("latency_sof", m_sof, 1'b1);
    push_pairs(10, 1, 3);
    chk("bp_level", fifo_level, 3'd4);
    chk("bp_overflow", overflow, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_data_hold", m_data, 24'h0A141E);
      chk("bp_sof_hold", m_sof, 1'b1);
    end
    chk("basic_p1_const", pix(10, 1), 24'h0B151F);
    drain(10, 0, 8);
    chk("basic_empty", m_valid, 1'b0);
    chk("basic_level", fifo_level, 3'd0);
    tick();
    chk("basic_fd_one_cycle", frame_done, 1'b0);

    // Full FIFO, phase ODD, transfer plus push in the same cycle
    push_pairs(8'h40, 0, 4);
    chk("fp_level_full", fifo_level, 3'd4);
    drain(8'h40, 0, 1);
    chk("fp_phase_odd", phase, 1'b1);
    set_pair(pix(8'h40, 8), pix(8'h40, 9));
    hsync = 1'b1;
    m_ready = 1'b1;
    chk("fp_odd_data", m_data, pix(8'h40, 1));
    tick();
    hsync = 1'b0;
    m_ready = 1'b0;
    pos = (pos + 1) % (W * H);
    chk("fp_level_kept", fifo_level, 3'd4);
    chk("fp_no_overflow", overflow, 1'b0);
    chk("fp_phase_even", phase, 1'b0);
    drain(8'h40, 2, 8);
    chk("fp_empty", m_valid, 1'b0);

    // Overflow: fifth pair is dropped
    push_pairs(8'h80, 0, 5);
    chk("ov_level", fifo_level, 3'd4);
    chk("ov_flag", overflow, 1'b1);
    drain(8'h80, 0, 8);
    chk("ov_empty", m_valid, 1'b0);
    chk("ov_sticky", overflow, 1'b1);

    // Mid-frame vsync flush
    push_pairs(8'hC0, 0, 2);
    drain(8'hC0, 0, 3);
    chk("vs_err_before", frame_error, 1'b0);
    vsync = 1'b1;
    tick();
    chk("vs_level", fifo_level, 3'd0);
    chk("vs_valid", m_valid, 1'b0);
    chk("vs_err", frame_error, 1'b1);
    tick();
    vsync = 1'b0;
    pos = 0;
    push_pairs(8'hC0, 5, 1);
    chk("vs_sof_after", m_sof, 1'b1);
    drain(8'hC0, 10, 2);

    // Asynchronous reset in the middle of a burst
    push_pairs(8'h20, 0, 2);
    chk("mr_level_before", fifo_level, 3'd2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mr_valid", m_valid, 1'b0);
    chk("mr_level", fifo_level, 3'd0);
    chk("mr_data", m_data, 24'd0);
    chk("mr_flags", {overflow, frame_error, frame_done}, 3'b000);
    chk("mr_phase", phase, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    chk("mr_level_after", fifo_level, 3'd0);
    pos = 0;
    push_pairs(8'h20, 0, 1);
    drain(8'h20, 0, 2);
    chk("mr_final_empty", m_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
